// File: rtl/alu_cmd_issuer_pkg.sv
// Shared definitions for the ALU command issuer: op codes and FSM states.
package alu_cmd_issuer_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_SLL  = 4'd4;
  localparam logic [3:0] OP_SRL  = 4'd5;
  localparam logic [3:0] OP_SRA  = 4'd6;
  localparam logic [3:0] OP_GT   = 4'd7;
  localparam logic [3:0] OP_LT   = 4'd8;
  localparam logic [3:0] OP_LAST = OP_LT;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Codes above OP_LAST have no ALU meaning.
  function automatic logic op_is_illegal(input logic [3:0] op);
    return op > OP_LAST;
  endfunction

endpackage

// File: rtl/alu_cmd_issuer_alu.sv
// Combinational 32-bit ALU. Overflow is only meaningful for add/sub.
module alu_cmd_issuer_alu
  import alu_cmd_issuer_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [4:0]  shamt_i,
  output logic [31:0] result_o,
  output logic        overflow_o
);

  logic [31:0] sum, diff;

  assign sum  = a_i + b_i;
  assign diff = a_i - b_i;

  // Select the result for the requested operation; unknown codes yield 0.
  always_comb begin
    result_o   = '0;
    overflow_o = 1'b0;
    case (op_i)
      OP_ADD: begin
        result_o   = sum;
        overflow_o = (a_i[31] == b_i[31]) && (sum[31] != a_i[31]);
      end
      OP_SUB: begin
        result_o   = diff;
        overflow_o = (a_i[31] != b_i[31]) && (diff[31] != a_i[31]);
      end
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_SLL:  result_o = a_i << shamt_i;
      OP_SRL:  result_o = a_i >> shamt_i;
      OP_SRA:  result_o = $unsigned($signed(a_i) >>> shamt_i);
      OP_GT:   result_o = {31'd0, $signed(a_i) > $signed(b_i)};
      OP_LT:   result_o = {31'd0, $signed(a_i) < $signed(b_i)};
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Command front end for the ALU: accepts one op, runs it from registered
// operands, holds the response until consumed. Tracks sticky overflow and
// a count of delivered responses.
module alu_cmd_issuer
  import alu_cmd_issuer_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [4:0]        cmd_shamt,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_overflow,
  output logic              rsp_illegal,
  input  logic              clr_sticky,
  output logic              sticky_ovf,
  output logic [CNT_W-1:0]  op_count
);

  state_e            state_q, state_d;
  logic [3:0]        op_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [4:0]        shamt_q;
  logic [DATA_W-1:0] res_q, res_d;
  logic              ovf_q, ovf_d;
  logic              ill_q, ill_d;
  logic              sticky_q, sticky_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              accept, capture, deliver;
  logic [DATA_W-1:0] alu_res;
  logic              alu_ovf;
  logic              cap_ill, cap_ovf;

  // Ready is withheld while reset is asserted, even though state already reads IDLE.
  assign cmd_ready = (state_q == ST_IDLE) && !rst;
  assign rsp_valid = (state_q == ST_RESP);
  assign accept    = cmd_valid && cmd_ready;
  assign deliver   = rsp_valid && rsp_ready;

  // ALU sees only the registered operands, never the live command bus.
  alu_cmd_issuer_alu u_alu (
    .op_i       (op_q),
    .a_i        (a_q),
    .b_i        (b_q),
    .shamt_i    (shamt_q),
    .result_o   (alu_res),
    .overflow_o (alu_ovf)
  );

  assign cap_ill = op_is_illegal(op_q);
  assign cap_ovf = ((op_q == OP_ADD) || (op_q == OP_SUB)) && alu_ovf;

  // Next-state logic: one cycle in EXEC, hold RESP until the consumer takes it.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_EXEC;
      ST_EXEC: begin
        capture = 1'b1;
        state_d = ST_RESP;
      end
      ST_RESP: if (deliver) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Response, sticky and counter next values; a set of sticky beats a clear.
  always_comb begin
    res_d    = res_q;
    ovf_d    = ovf_q;
    ill_d    = ill_q;
    sticky_d = sticky_q && !clr_sticky;
    cnt_d    = cnt_q;
    if (capture) begin
      res_d = cap_ill ? '0 : alu_res;
      ovf_d = cap_ovf;
      ill_d = cap_ill;
      if (cap_ovf) sticky_d = 1'b1;
    end
    if (deliver) cnt_d = cnt_q + 1'b1;
  end

  // State and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      res_q    <= '0;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      res_q    <= res_d;
      ovf_q    <= ovf_d;
      ill_q    <= ill_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  // Operand registers load only on an accepted command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      shamt_q <= '0;
    end else if (accept) begin
      op_q    <= cmd_op;
      a_q     <= cmd_a;
      b_q     <= cmd_b;
      shamt_q <= cmd_shamt;
    end
  end

  assign rsp_result   = res_q;
  assign rsp_overflow = ovf_q;
  assign rsp_illegal  = ill_q;
  assign sticky_ovf   = sticky_q;
  assign op_count     = cnt_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Scoreboard bench for alu_cmd_issuer. Counter is built narrow so wrap is reachable.
module tb_alu_cmd_issuer;

  localparam int CW = 4;

  typedef struct {
    logic [31:0] r;
    logic        o;
    logic        i;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [3:0]    cmd_op = '0;
  logic [31:0]   cmd_a = '0, cmd_b = '0;
  logic [4:0]    cmd_shamt = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [31:0]   rsp_result;
  logic          rsp_overflow, rsp_illegal;
  logic          clr_sticky = 1'b0;
  logic          sticky_ovf;
  logic [CW-1:0] op_count;

  int            checks = 0;
  int            failures = 0;
  logic [CW-1:0] exp_cnt = '0;
  exp_t          sb[$];

  alu_cmd_issuer #(.DATA_W(32), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_shamt(cmd_shamt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_overflow(rsp_overflow), .rsp_illegal(rsp_illegal),
    .clr_sticky(clr_sticky), .sticky_ovf(sticky_ovf), .op_count(op_count)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, b,
                                 input logic [4:0] sh);
    exp_t e;
    logic signed [32:0] wide;
    e.r = '0; e.o = 1'b0; e.i = 1'b0;
    case (op)
      4'd0: begin
        wide = $signed({a[31], a}) + $signed({b[31], b});
        e.r = wide[31:0];
        e.o = (wide > 33'sd2147483647) || (wide < -33'sd2147483648);
      end
      4'd1: begin
        wide = $signed({a[31], a}) - $signed({b[31], b});
        e.r = wide[31:0];
        e.o = (wide > 33'sd2147483647) || (wide < -33'sd2147483648);
      end
      4'd2: e.r = a & b;
      4'd3: e.r = a | b;
      4'd4: for (int k = 0; k < 32; k++) e.r[k] = (k >= sh) ? a[k - sh] : 1'b0;
      5'd5: for (int k = 0; k < 32; k++) e.r[k] = (k + sh < 32) ? a[k + sh] : 1'b0;
      4'd6: for (int k = 0; k < 32; k++) e.r[k] = (k + sh < 32) ? a[k + sh] : a[31];
      4'd7: e.r = ($signed(a) > $signed(b)) ? 32'd1 : 32'd0;
      4'd8: e.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: e.i = 1'b1;
    endcase
    return e;
  endfunction

  // Present a command from a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic [3:0] op, input logic [31:0] a, b,
                      input logic [4:0] sh, output bit ok);
    int n = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_shamt = sh;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    ok = cmd_ready;
    if (ok) sb.push_back(model(op, a, b, sh));
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Count negedges until rsp_valid, bounded.
  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
  endtask

  function automatic exp_t pop_exp();
    exp_t e;
    e.r = 32'hDEADBEEF; e.o = 1'bx; e.i = 1'bx;
    if (sb.size() != 0) e = sb.pop_front();
    return e;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_result !== 32'd0 ||
        rsp_overflow !== 1'b0 || rsp_illegal !== 1'b0 || sticky_ovf !== 1'b0 ||
        op_count !== '0) begin
      failures++;
      $display("FAIL reset_state rdy=%b vld=%b res=%h ovf=%b ill=%b sticky=%b cnt=%0d (want 0s)",
               cmd_ready, rsp_valid, rsp_result, rsp_overflow, rsp_illegal, sticky_ovf, op_count);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready got=%b want=1", cmd_ready);
    end
  endtask

  task automatic test_add();
    bit ok; int n; exp_t e;
    rsp_ready = 1'b1;
    send(4'd0, 32'd12, 32'd15, 5'd0, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL add_accept got=0 want=1"); end
    wait_rsp(n);
    checks++;
    if (n !== 1) begin failures++; $display("FAIL add_latency got=%0d want=1 cycle after EXEC", n); end
    e = pop_exp();
    checks++;
    if (rsp_result !== e.r || rsp_overflow !== e.o || rsp_illegal !== e.i) begin
      failures++;
      $display("FAIL add_rsp got=%h/%b/%b want=%h/%b/%b", rsp_result, rsp_overflow, rsp_illegal, e.r, e.o, e.i);
    end
    @(negedge clk); exp_cnt++;
    checks++;
    if (op_count !== exp_cnt || rsp_valid !== 1'b0) begin
      failures++; $display("FAIL add_count got=%0d vld=%b want=%0d vld=0", op_count, rsp_valid, exp_cnt);
    end
  endtask

  task automatic test_sticky();
    bit ok; int n; exp_t e;
    send(4'd0, 32'h7FFFFFFF, 32'd5, 5'd0, ok);
    wait_rsp(n);
    e = pop_exp();
    checks++;
    if (!ok || n !== 1 || rsp_result !== e.r || rsp_overflow !== e.o || sticky_ovf !== 1'b1) begin
      failures++;
      $display("FAIL ovf_add got=%h/%b sticky=%b want=%h/%b sticky=1", rsp_result, rsp_overflow, sticky_ovf, e.r, e.o);
    end
    @(negedge clk); exp_cnt++;
    // Clear lands on the same edge that captures another overflow.
    send(4'd1, 32'h80000000, 32'd100, 5'd0, ok);
    clr_sticky = 1'b1;
    wait_rsp(n);
    clr_sticky = 1'b0;
    e = pop_exp();
    checks++;
    if (!ok || rsp_result !== e.r || rsp_overflow !== e.o || sticky_ovf !== 1'b1) begin
      failures++;
      $display("FAIL ovf_sub_setwins got=%h/%b sticky=%b want=%h/%b sticky=1", rsp_result, rsp_overflow, sticky_ovf, e.r, e.o);
    end
    @(negedge clk); exp_cnt++;
    clr_sticky = 1'b1;
    @(negedge clk);
    clr_sticky = 1'b0;
    checks++;
    if (sticky_ovf !== 1'b0) begin failures++; $display("FAIL sticky_clear got=%b want=0", sticky_ovf); end
  endtask

  task automatic test_ops();
    logic [3:0]  ops[10] = '{4'd6, 4'd5, 4'd8, 4'd4, 4'd2, 4'd3, 4'd7, 4'd7, 4'd1, 4'd6};
    logic [31:0] as[10]  = '{32'hFFFFFFF0, 32'hFFFFFFFF, -32'sd13, 32'h0000_00F1, 32'hF0F0_1234,
                             32'h0F00_0001, 32'd5, -32'sd5, 32'd10, 32'h4000_0000};
    logic [31:0] bs[10]  = '{32'd0, 32'd0, 32'd20, 32'd0, 32'h0FF0_FF00, 32'h1000_0010,
                             -32'sd7, 32'd3, 32'd30, 32'd0};
    logic [4:0]  shs[10] = '{5'd5, 5'd5, 5'd0, 5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd3};
    bit ok; int n; exp_t e;
    for (int i = 0; i < 10; i++) begin
      send(ops[i], as[i], bs[i], shs[i], ok);
      wait_rsp(n);
      e = pop_exp();
      checks++;
      if (!ok || n !== 1 || rsp_result !== e.r || rsp_overflow !== e.o || rsp_illegal !== e.i) begin
        failures++;
        $display("FAIL op%0d_idx%0d got=%h/%b/%b want=%h/%b/%b", ops[i], i,
                 rsp_result, rsp_overflow, rsp_illegal, e.r, e.o, e.i);
      end
      @(negedge clk); exp_cnt++;
    end
    checks++;
    if (op_count !== exp_cnt) begin failures++; $display("FAIL ops_count got=%0d want=%0d", op_count, exp_cnt); end
  endtask

  task automatic test_illegal();
    logic [3:0] ops[3] = '{4'd12, 4'd9, 4'd15};
    bit ok; int n; exp_t e;
    for (int i = 0; i < 3; i++) begin
      send(ops[i], 32'h7FFFFFFF, 32'd1, 5'd3, ok);
      wait_rsp(n);
      e = pop_exp();
      checks++;
      if (!ok || rsp_result !== 32'd0 || rsp_overflow !== 1'b0 || rsp_illegal !== 1'b1 || e.i !== 1'b1) begin
        failures++;
        $display("FAIL illegal_op%0d got=%h/%b/%b want=0/0/1", ops[i], rsp_result, rsp_overflow, rsp_illegal);
      end
      @(negedge clk); exp_cnt++;
      checks++;
      if (op_count !== exp_cnt) begin failures++; $display("FAIL illegal_count got=%0d want=%0d", op_count, exp_cnt); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok; int n; exp_t e;
    rsp_ready = 1'b0;
    send(4'd0, 32'd1, 32'd2, 5'd0, ok);
    wait_rsp(n);
    e = pop_exp();
    cmd_valid = 1'b1; cmd_op = 4'd1; cmd_a = 32'd10; cmd_b = 32'd3; cmd_shamt = 5'd0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== e.r || cmd_ready !== 1'b0 || op_count !== exp_cnt) begin
        failures++;
        $display("FAIL bp_hold_c%0d vld=%b res=%h rdy=%b cnt=%0d want 1/%h/0/%0d", i,
                 rsp_valid, rsp_result, cmd_ready, op_count, e.r, exp_cnt);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk); exp_cnt++;
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || op_count !== exp_cnt) begin
      failures++;
      $display("FAIL bp_release rdy=%b vld=%b cnt=%0d want 1/0/%0d", cmd_ready, rsp_valid, op_count, exp_cnt);
    end
    sb.push_back(model(4'd1, 32'd10, 32'd3, 5'd0));
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      failures++; $display("FAIL bp_second_exec rdy=%b vld=%b want 0/0", cmd_ready, rsp_valid);
    end
    wait_rsp(n);
    e = pop_exp();
    checks++;
    if (n !== 1 || rsp_result !== e.r) begin
      failures++; $display("FAIL bp_second_rsp got=%h n=%0d want=%h n=1", rsp_result, n, e.r);
    end
    @(negedge clk); exp_cnt++;
  endtask

  task automatic test_rst_midop();
    bit ok; int n; exp_t e; int seen = 0;
    send(4'd0, 32'h7FFFFFFF, 32'd1, 5'd0, ok);
    wait_rsp(n);
    e = pop_exp();
    @(negedge clk); exp_cnt++;
    send(4'd0, 32'd40, 32'd2, 5'd0, ok);
    rst = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_result !== 32'd0 || rsp_overflow !== 1'b0 ||
        rsp_illegal !== 1'b0 || sticky_ovf !== 1'b0 || op_count !== '0) begin
      failures++;
      $display("FAIL rst_mid_state rdy=%b vld=%b res=%h ovf=%b ill=%b sticky=%b cnt=%0d want all 0",
               cmd_ready, rsp_valid, rsp_result, rsp_overflow, rsp_illegal, sticky_ovf, op_count);
    end
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    exp_cnt = '0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen != 0 || op_count !== '0 || cmd_ready !== 1'b1) begin
      failures++; $display("FAIL rst_mid_drop rsp_seen=%0d cnt=%0d rdy=%b want 0/0/1", seen, op_count, cmd_ready);
    end
  endtask

  task automatic test_wrap();
    bit ok; int n; exp_t e;
    for (int i = 0; i < 17; i++) begin
      send(4'd3, i, 32'd0, 5'd0, ok);
      wait_rsp(n);
      e = pop_exp();
      @(negedge clk); exp_cnt++;
    end
    checks++;
    if (op_count !== 4'd1 || exp_cnt !== 4'd1) begin
      failures++; $display("FAIL count_wrap got=%0d want=1", op_count);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sticky();
    test_ops();
    test_illegal();
    test_back_to_back();
    test_rst_midop();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog sim time exceeded");
    $fatal(1, "watchdog");
  end

endmodule
